// File: rtl/if_else_emitter_pkg.sv
// Shared definitions for the if-else statement emitter: comparator codes,
// FSM/segment encodings, ASCII constants and character-lookup helpers.
package if_else_emitter_pkg;

    typedef enum logic [2:0] {
        CMP_EQ = 3'd0,
        CMP_NE = 3'd1,
        CMP_LT = 3'd2,
        CMP_GT = 3'd3,
        CMP_LE = 3'd4,
        CMP_GE = 3'd5
    } cmp_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CONV_V,
        ST_CONV_1,
        ST_CONV_2,
        ST_EMIT
    } state_t;

    // Template segments in emission order; SEG_MINUS is skipped for valc >= 0.
    typedef enum logic [3:0] {
        SEG_IF,
        SEG_OP,
        SEG_MINUS,
        SEG_DV,
        SEG_P1,
        SEG_D1,
        SEG_ELSE,
        SEG_D2,
        SEG_SEMI
    } seg_t;

    localparam logic [6:0] ASC_ZERO  = 7'h30;
    localparam logic [6:0] ASC_MINUS = 7'h2D;
    localparam logic [6:0] ASC_LT    = 7'h3C;
    localparam logic [6:0] ASC_GT    = 7'h3E;
    localparam logic [6:0] ASC_EQ    = 7'h3D;
    localparam logic [6:0] ASC_BANG  = 7'h21;
    localparam logic [6:0] ASC_SEMI  = 7'h3B;
    localparam logic [6:0] ASC_SPACE = 7'h20;

    localparam logic [31:0] TXT_IF   = "if x";
    localparam logic [31:0] TXT_P    = " p<=";
    localparam logic [71:0] TXT_ELSE = " else p<=";

    localparam logic [3:0] LEN_IF    = 4'd4;
    localparam logic [3:0] LEN_MINUS = 4'd1;
    localparam logic [3:0] LEN_P     = 4'd4;
    localparam logic [3:0] LEN_ELSE  = 4'd9;
    localparam logic [3:0] LEN_SEMI  = 4'd1;

    function automatic logic cmp_legal(input logic [2:0] cmp);
        return cmp <= 3'd5;
    endfunction

    function automatic logic [3:0] op_len(input logic [2:0] cmp);
        return (cmp == CMP_LT || cmp == CMP_GT) ? 4'd1 : 4'd2;
    endfunction

    function automatic logic [6:0] op_char(input logic [2:0] cmp, input logic [3:0] pos);
        logic [6:0] c;
        c = ASC_EQ;
        if (pos == 4'd0) begin
            case (cmp)
                CMP_NE:         c = ASC_BANG;
                CMP_LT, CMP_LE: c = ASC_LT;
                CMP_GT, CMP_GE: c = ASC_GT;
                default:        c = ASC_EQ;
            endcase
        end
        return c;
    endfunction

    // Fixed text is stored right-aligned; character pos counts from the left.
    function automatic logic [6:0] fixed_char(input seg_t seg, input logic [3:0] pos);
        logic [71:0] txt;
        logic [71:0] sh;
        logic [3:0]  len;
        logic [3:0]  idx;
        case (seg)
            SEG_IF:   begin txt = {40'd0, TXT_IF}; len = LEN_IF;   end
            SEG_P1:   begin txt = {40'd0, TXT_P};  len = LEN_P;    end
            SEG_ELSE: begin txt = TXT_ELSE;        len = LEN_ELSE; end
            default:  begin txt = {65'd0, ASC_SEMI}; len = LEN_SEMI; end
        endcase
        idx = len - pos - 4'd1;
        sh  = txt >> {idx, 3'b000};
        return sh[6:0];
    endfunction

    function automatic logic [6:0] digit_char(input logic [39:0] bcd, input logic [3:0] digits,
                                              input logic [3:0] pos);
        logic [3:0]  idx;
        logic [39:0] sh;
        idx = digits - pos - 4'd1;
        sh  = bcd >> {idx, 2'b00};
        return ASC_ZERO + {3'b000, sh[3:0]};
    endfunction

endpackage

// File: rtl/if_else_emitter_u32_to_bcd.sv
// Sequential double-dabble: 32-bit unsigned to 10 BCD digits in 32 clock edges,
// plus the count of significant digits (at least 1).
module u32_to_bcd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [31:0] bin,
    output logic [39:0] bcd,
    output logic [3:0]  digits,
    output logic        done
);

    logic [31:0] shift_reg;
    logic [39:0] bcd_reg;
    logic [4:0]  cnt_reg;
    logic        run_reg;
    logic        done_reg;
    logic [39:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_adj
            assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                                      : bcd_reg[4*gi +: 4];
        end
    endgenerate

    // The load edge performs the first shift (nothing to adjust from zero),
    // so 32 edges total yield the finished result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
            cnt_reg   <= '0;
            run_reg   <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg <= {bin[30:0], 1'b0};
                bcd_reg   <= {39'd0, bin[31]};
                cnt_reg   <= 5'd1;
                run_reg   <= 1'b1;
            end else if (run_reg) begin
                shift_reg <= {shift_reg[30:0], 1'b0};
                bcd_reg   <= {bcd_adj[38:0], shift_reg[31]};
                cnt_reg   <= cnt_reg + 5'd1;
                if (cnt_reg == 5'd31) begin
                    run_reg  <= 1'b0;
                    done_reg <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        digits = 4'd1;
        for (int i = 1; i < 10; i++) begin
            if (bcd_reg[4*i +: 4] != 4'd0) digits = 4'(i + 1);
        end
    end

    assign bcd  = bcd_reg;
    assign done = done_reg;

endmodule

// File: rtl/if_else_emitter.sv
// Serialises a decoded if-else assignment into ASCII characters over a
// valid/ready interface after converting all three constants to decimal.
module if_else_emitter
    import if_else_emitter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  comparator,
    input  logic [31:0] valc,
    input  logic [31:0] const1,
    input  logic [31:0] const2,
    output logic [6:0]  ascii_char,
    output logic        char_valid,
    input  logic        char_ready,
    output logic        busy,
    output logic        done,
    output logic        error_flag
);

    state_t      state_reg, state_next;
    seg_t        seg_reg, seg_next;
    logic [3:0]  pos_reg, pos_next;
    logic [2:0]  comp_reg;
    logic        neg_reg;
    logic [31:0] mag_reg, c1_reg, c2_reg;
    logic [39:0] bcd_v_reg, bcd_1_reg, bcd_2_reg;
    logic [3:0]  dig_v_reg, dig_1_reg, dig_2_reg;
    logic        busy_reg, done_reg, error_reg;

    logic        conv_start;
    logic [31:0] conv_in;
    logic [39:0] conv_bcd;
    logic [3:0]  conv_digits;
    logic        conv_done;
    logic [3:0]  seg_len;
    logic [6:0]  cur_char;

    u32_to_bcd u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (conv_start),
        .bin    (conv_in),
        .bcd    (conv_bcd),
        .digits (conv_digits),
        .done   (conv_done)
    );

    always_comb begin
        seg_len = LEN_SEMI;
        case (seg_reg)
            SEG_IF:    seg_len = LEN_IF;
            SEG_OP:    seg_len = op_len(comp_reg);
            SEG_MINUS: seg_len = LEN_MINUS;
            SEG_DV:    seg_len = dig_v_reg;
            SEG_P1:    seg_len = LEN_P;
            SEG_D1:    seg_len = dig_1_reg;
            SEG_ELSE:  seg_len = LEN_ELSE;
            SEG_D2:    seg_len = dig_2_reg;
            default:   seg_len = LEN_SEMI;
        endcase
    end

    always_comb begin
        cur_char = ASC_SPACE;
        case (seg_reg)
            SEG_OP:    cur_char = op_char(comp_reg, pos_reg);
            SEG_MINUS: cur_char = ASC_MINUS;
            SEG_DV:    cur_char = digit_char(bcd_v_reg, dig_v_reg, pos_reg);
            SEG_D1:    cur_char = digit_char(bcd_1_reg, dig_1_reg, pos_reg);
            SEG_D2:    cur_char = digit_char(bcd_2_reg, dig_2_reg, pos_reg);
            default:   cur_char = fixed_char(seg_reg, pos_reg);
        endcase
    end

    // Output is decoded from state so reset drops char_valid without a clock.
    assign char_valid = (state_reg == ST_EMIT);
    assign ascii_char = char_valid ? cur_char : 7'd0;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign error_flag = error_reg;

    always_comb begin
        state_next = state_reg;
        seg_next   = seg_reg;
        pos_next   = pos_reg;
        conv_start = 1'b0;
        conv_in    = mag_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start && cmp_legal(comparator)) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                conv_start = 1'b1;
                conv_in    = mag_reg;
                state_next = ST_CONV_V;
            end
            ST_CONV_V: begin
                if (conv_done) begin
                    conv_start = 1'b1;
                    conv_in    = c1_reg;
                    state_next = ST_CONV_1;
                end
            end
            ST_CONV_1: begin
                if (conv_done) begin
                    conv_start = 1'b1;
                    conv_in    = c2_reg;
                    state_next = ST_CONV_2;
                end
            end
            ST_CONV_2: begin
                if (conv_done) begin
                    state_next = ST_EMIT;
                    seg_next   = SEG_IF;
                    pos_next   = 4'd0;
                end
            end
            ST_EMIT: begin
                if (char_ready) begin
                    if (pos_reg == seg_len - 4'd1) begin
                        pos_next = 4'd0;
                        case (seg_reg)
                            SEG_IF:    seg_next = SEG_OP;
                            SEG_OP:    seg_next = neg_reg ? SEG_MINUS : SEG_DV;
                            SEG_MINUS: seg_next = SEG_DV;
                            SEG_DV:    seg_next = SEG_P1;
                            SEG_P1:    seg_next = SEG_D1;
                            SEG_D1:    seg_next = SEG_ELSE;
                            SEG_ELSE:  seg_next = SEG_D2;
                            SEG_D2:    seg_next = SEG_SEMI;
                            default:   state_next = ST_IDLE;
                        endcase
                    end else begin
                        pos_next = pos_reg + 4'd1;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            seg_reg   <= SEG_IF;
            pos_reg   <= '0;
            comp_reg  <= '0;
            neg_reg   <= 1'b0;
            mag_reg   <= '0;
            c1_reg    <= '0;
            c2_reg    <= '0;
            bcd_v_reg <= '0;
            bcd_1_reg <= '0;
            bcd_2_reg <= '0;
            dig_v_reg <= '0;
            dig_1_reg <= '0;
            dig_2_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            seg_reg   <= seg_next;
            pos_reg   <= pos_next;
            done_reg  <= 1'b0;
            if (state_reg == ST_IDLE && start) begin
                if (cmp_legal(comparator)) begin
                    comp_reg  <= comparator;
                    neg_reg   <= valc[31];
                    mag_reg   <= valc[31] ? (~valc + 32'd1) : valc;
                    c1_reg    <= const1;
                    c2_reg    <= const2;
                    busy_reg  <= 1'b1;
                    error_reg <= 1'b0;
                end else begin
                    error_reg <= 1'b1;
                end
            end
            if (conv_done) begin
                case (state_reg)
                    ST_CONV_V: begin bcd_v_reg <= conv_bcd; dig_v_reg <= conv_digits; end
                    ST_CONV_1: begin bcd_1_reg <= conv_bcd; dig_1_reg <= conv_digits; end
                    ST_CONV_2: begin bcd_2_reg <= conv_bcd; dig_2_reg <= conv_digits; end
                    default: ;
                endcase
            end
            if (state_reg == ST_EMIT && state_next == ST_IDLE) begin
                busy_reg <= 1'b0;
                done_reg <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_else_emitter.sv
// Randomised bench for if_else_emitter against a string-level model of the statement text.
module tb_if_else_emitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  comparator = 3'd0;
    logic [31:0] valc = 32'd0;
    logic [31:0] const1 = 32'd0;
    logic [31:0] const2 = 32'd0;
    logic [6:0]  ascii_char;
    logic        char_valid;
    logic        char_ready = 1'b1;
    logic        busy;
    logic        done;
    logic        error_flag;

    int n_cmp = 0;
    int n_bad = 0;

    if_else_emitter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .comparator (comparator),
        .valc       (valc),
        .const1     (const1),
        .const2     (const2),
        .ascii_char (ascii_char),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .busy       (busy),
        .done       (done),
        .error_flag (error_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic string expect_text(input logic [2:0] cmp, input logic [31:0] v,
                                          input logic [31:0] c1, input logic [31:0] c2);
        string       op;
        string       sign;
        logic [31:0] mag;
        case (cmp)
            3'd0:    op = "==";
            3'd1:    op = "!=";
            3'd2:    op = "<";
            3'd3:    op = ">";
            3'd4:    op = "<=";
            default: op = ">=";
        endcase
        sign = "";
        if (v[31]) sign = "-";
        mag = v[31] ? (32'd0 - v) : v;
        return {"if x", op, sign, $sformatf("%0d", mag), " p<=", $sformatf("%0d", c1),
                " else p<=", $sformatf("%0d", c2), ";"};
    endfunction

    task automatic run_stmt(input logic [2:0] cmp, input logic [31:0] v, input logic [31:0] c1,
                            input logic [31:0] c2, input bit rand_ready, input bit poke_busy);
        string       exp;
        byte unsigned got_q[$];
        int          c, first, last, n;
        bit          finished, stalled, rdy;
        logic [6:0]  held;
        exp = expect_text(cmp, v, c1, c2);
        comparator = cmp; valc = v; const1 = c1; const2 = c2;
        char_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 0; first = -1; last = -1; finished = 0; stalled = 0; held = '0;
        while (!finished && c < 1000) begin
            if (c == 0) begin
                check("busy_after_accept", busy, 1);
                check("error_after_accept", error_flag, 0);
                comparator = 3'($urandom_range(0, 7));
                valc = $urandom; const1 = $urandom; const2 = $urandom;
            end
            if (poke_busy && c == 100) begin
                start = 1'b1;
                comparator = 3'($urandom_range(0, 5));
            end
            if (poke_busy && c == 101) start = 1'b0;
            if (stalled) begin
                check("hold_valid", char_valid, 1);
                check("hold_char", ascii_char, held);
            end
            if (done) begin
                check("busy_at_done", busy, 0);
                check("done_after_last", c, last + 1);
                if (!rand_ready) check("done_cycle", c, 97 + exp.len());
                finished = 1;
            end else begin
                if (char_valid && first < 0) first = c;
                rdy = rand_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                char_ready = rdy;
                if (char_valid && rdy) begin
                    got_q.push_back(8'(ascii_char));
                    last = c;
                    stalled = 0;
                end else begin
                    stalled = char_valid;
                    held = ascii_char;
                end
                @(negedge clk);
                c++;
            end
        end
        char_ready = 1'b1;
        if (!finished) check("timeout_done", 0, 1);
        check("first_valid_cycle", first, 97);
        check("length", got_q.size(), exp.len());
        n = (got_q.size() < exp.len()) ? got_q.size() : exp.len();
        for (int i = 0; i < n; i++) check($sformatf("char%0d", i), got_q[i], exp[i]);
        $display("stmt \"%s\" cmp=%0d ready_rand=%0d chars=%0d first_valid=T+%0d",
                 exp, cmp, rand_ready, got_q.size(), first);
    endtask

    task automatic run_illegal();
        int seen;
        comparator = 3'd7; valc = $urandom; const1 = $urandom; const2 = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("illegal_error", error_flag, 1);
        check("illegal_busy", busy, 0);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            if (char_valid || done || busy) seen++;
            @(negedge clk);
        end
        check("illegal_quiet", seen, 0);
        check("illegal_sticky", error_flag, 1);
        $display("illegal comparator 7: error_flag=%0d activity=%0d", error_flag, seen);
    endtask

    task automatic run_reset_mid();
        comparator = 3'd4; valc = -32'sd12; const1 = 32'd3; const2 = 32'd450;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (105) @(negedge clk);
        check("midstream_valid", char_valid, 1);
        rst_n = 1'b0;
        #1;
        check("reset_valid_async", char_valid, 0);
        check("reset_busy_async", busy, 0);
        check("reset_char_async", ascii_char, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_resume_valid", char_valid, 0);
        check("no_resume_busy", busy, 0);
        $display("reset mid-emit: char_valid=%0d busy=%0d", char_valid, busy);
    endtask

    initial begin
        logic [2:0]  cmp;
        logic [31:0] v;
        repeat (3) @(negedge clk);
        check("reset_char", ascii_char, 0);
        check("reset_valid", char_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_error", error_flag, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_stmt(3'd4, -32'sd12, 32'd3, 32'd450, 1'b0, 1'b0);
        run_stmt(3'd4, -32'sd12, 32'd3, 32'd450, 1'b1, 1'b0);
        run_stmt(3'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_stmt(3'd5, 32'h8000_0000, 32'd7, 32'd1000000000, 1'b0, 1'b0);
        run_stmt(3'd0, 32'd99, 32'd10, 32'd9, 1'b0, 1'b0);
        run_stmt(3'd1, 32'h7FFF_FFFF, 32'd1, 32'd100, 1'b0, 1'b0);
        run_illegal();
        run_stmt(3'd3, -32'sd1, 32'd5, 32'd6, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) begin
            cmp = 3'($urandom_range(0, 5));
            v = (k % 2 == 0) ? 32'($urandom_range(0, 2000)) - 32'd1000 : $urandom;
            run_stmt(cmp, v, $urandom >> $urandom_range(0, 31), $urandom >> $urandom_range(0, 31),
                     1'($urandom_range(0, 1)), 1'(k % 3 == 0));
        end
        run_reset_mid();
        run_stmt(3'd4, -32'sd12, 32'd3, 32'd450, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_else_emitter.md
# if_else_emitter

Serializer that turns a decoded if-else assignment (comparator, condition constant, two branch constants) into the ASCII character stream consumed by the if-else parser, one 7-bit character per transfer. It sits upstream of the parser: a test/config master loads the fields with a start pulse, and the block pre-converts all three numbers to decimal, then streams the statement over a valid/ready character interface. Its output text round-trips through the parser to the same p-selection.

## Interface
- No parameters; all widths fixed at 32-bit data, 7-bit ASCII.
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  load request; sampled only in IDLE
- comparator  in  3  EQ=000, NE=001, LT=010, GT=011, LE=100, GE=101; 110/111 illegal
- valc  in  32  condition constant, signed two's complement
- const1  in  32  if-branch constant, unsigned
- const2  in  32  else-branch constant, unsigned
- ascii_char  out  7  current character
- char_valid  out  1  ascii_char valid
- char_ready  in  1  sink accepts; tie high for the parser
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last character transfer
- error_flag  out  1  sticky: illegal comparator seen; cleared by next accepted start

## Operation
- Emitted text, no spaces except shown: "if x" OP [ "-" ] DEC(|valc|) " p<=" DEC(const1) " else p<=" DEC(const2) ";"
- OP: EQ "==", NE "!=", LT "<", GT ">", LE "<=", GE ">=".
- "-" only when valc[31]=1; magnitude computed as unsigned 32-bit (valc=-2147483648 -> "2147483648").
- DEC: most significant digit first, leading zeros suppressed, value 0 -> "0"; 1..10 digits.
- States: IDLE -> LOAD -> CONV_V -> CONV_1 -> CONV_2 -> EMIT -> IDLE.
- IDLE: start=1 latches all inputs, busy<=1, error_flag<=0. Illegal comparator: error_flag<=1, busy stays 0, return/stay IDLE, no characters, no done.
- CONV_x: one 32-cycle binary-to-BCD conversion each; result (10 BCD digits + digit count) stored per field.
- EMIT: character index walks the fixed template; digit fields index the stored BCD from its first significant digit.
- Transfer occurs on a cycle with char_valid=1 and char_ready=1; index advances only then.
- start while busy: ignored, latched fields unchanged.
- Input fields may change freely after the accepting edge.

## Timing
- Reset values: ascii_char=0, char_valid=0, busy=0, done=0, error_flag=0; FSM IDLE; all buffers 0. Reset assertion mid-stream drops char_valid asynchronously; no partial resume.
- Accepting edge = T. busy=1 from T. Conversions occupy T+1..T+96 (32 cycles each, back-to-back). First char_valid=1 at T+97.
- With char_ready held high: one character per cycle, no bubbles; N-character statement completes transfers at T+97..T+96+N.
- char_ready low: ascii_char and char_valid held stable until transfer.
- done=1 and busy=0 on the cycle after the last transfer; new start accepted that same cycle.

## Structure
- Shared package: comparator codes, ASCII constants ("0", "-", "<", ">", "=", "!", ";", space), template segment lengths.
- Sub-module u32_to_bcd: sequential double-dabble, start/done, 32-cycle latency, 40-bit BCD out plus 4-bit significant-digit count; instantiated once, reused for all three fields.

## Test plan
- LE, valc=-12, const1=3, const2=450, ready=1 -> "if x<=-12 p<=3 else p<=450;" (27 chars), first valid at T+97, done at T+124.
- LT, valc=0, const1=0, const2=4294967295 -> "if x<0 p<=0 else p<=4294967295;".
- GE, valc=-2147483648 -> condition field "-2147483648"; EQ/NE produce "==" and "!=".
- Random char_ready toggling on the first test -> identical character sequence, each char held stable while stalled.
- comparator=111 -> error_flag=1, no char_valid, no done; next legal start clears error_flag and emits normally.
- Loopback into the parser for all six comparators with x around valc (valc-1, valc, valc+1) -> parser p equals expected branch; rst_n pulsed mid-EMIT -> char_valid=0 immediately, busy=0.
